dual_down_counter: RTL and testbench

//   Two independent WIDTH-bit down-counters sharing one load/enable port, steered by Slt.

---
 rtl/dual_down_counter.sv | 106 ++++++++++
 tb/tb_dual_down_counter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/dual_down_counter.sv
// Two independent down-counters sharing one load/enable port, steered by Slt.
// Optional feature macro: AUTO_RELOAD_EN (reload the count on expiry instead of stopping at 0).
module dual_down_counter #(
    parameter int WIDTH = 64
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Slt,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    output logic [WIDTH-1:0] Output0,
    output logic [WIDTH-1:0] Output1,
    output logic             Zero0,
    output logic             Zero1,
    output logic             Done0,
    output logic             Done1
);

    // state | meaning
    // IDLE  | count == 0, decrement requests are ignored (saturate at 0)
    // RUN   | count != 0, En decrements toward expiry
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state  [2];
    state_t           w_state_nxt [2];
    logic [WIDTH-1:0] r_cnt    [2];
    logic [WIDTH-1:0] w_cnt_nxt [2];
    logic             r_done   [2];
    logic             w_done_nxt [2];
    logic             w_sel    [2];
`ifdef AUTO_RELOAD_EN
    logic [WIDTH-1:0] r_reload [2];
    logic [WIDTH-1:0] w_reload_nxt [2];
`endif

    assign w_sel[0] = ~Slt;
    assign w_sel[1] = Slt;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int ch = 0; ch < 2; ch++) begin
                r_state[ch]  <= IDLE;
                r_cnt[ch]    <= '0;
                r_done[ch]   <= 1'b0;
`ifdef AUTO_RELOAD_EN
                r_reload[ch] <= '0;
`endif
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                r_state[ch]  <= w_state_nxt[ch];
                r_cnt[ch]    <= w_cnt_nxt[ch];
                r_done[ch]   <= w_done_nxt[ch];
`ifdef AUTO_RELOAD_EN
                r_reload[ch] <= w_reload_nxt[ch];
`endif
            end
        end
    end

    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            w_state_nxt[ch]  = r_state[ch];
            w_cnt_nxt[ch]    = r_cnt[ch];
            w_done_nxt[ch]   = 1'b0;
`ifdef AUTO_RELOAD_EN
            w_reload_nxt[ch] = r_reload[ch];
`endif
            if (w_sel[ch]) begin
                if (Load) begin
                    w_cnt_nxt[ch]   = LoadVal;
                    w_state_nxt[ch] = (LoadVal != '0) ? RUN : IDLE;
`ifdef AUTO_RELOAD_EN
                    w_reload_nxt[ch] = LoadVal;
`endif
                end else if (En && (r_state[ch] == RUN)) begin
                    if (r_cnt[ch] == WIDTH'(1)) begin
                        w_done_nxt[ch] = 1'b1;
`ifdef AUTO_RELOAD_EN
                        // A zero reload value falls back to plain expiry.
                        w_cnt_nxt[ch]   = r_reload[ch];
                        w_state_nxt[ch] = (r_reload[ch] != '0) ? RUN : IDLE;
`else
                        w_cnt_nxt[ch]   = '0;
                        w_state_nxt[ch] = IDLE;
`endif
                    end else begin
                        w_cnt_nxt[ch] = r_cnt[ch] - WIDTH'(1);
                    end
                end
            end
        end
    end

    assign Output0 = r_cnt[0];
    assign Output1 = r_cnt[1];
    assign Zero0   = (r_cnt[0] == '0);
    assign Zero1   = (r_cnt[1] == '0);
    assign Done0   = r_done[0];
    assign Done1   = r_done[1];

endmodule

// File: tb/tb_dual_down_counter.sv
// Scoreboard bench for dual_down_counter: directed vectors push expected outputs,
// a negedge monitor pops and compares one entry per clock.
module tb_dual_down_counter;

    localparam int WIDTH = 64;
    localparam logic [WIDTH-1:0] ALL1 = {WIDTH{1'b1}};

    logic             Clk = 1'b0;
    logic             Reset;
    logic             En;
    logic             Slt;
    logic             Load;
    logic [WIDTH-1:0] LoadVal;
    logic [WIDTH-1:0] Output0;
    logic [WIDTH-1:0] Output1;
    logic             Zero0;
    logic             Zero1;
    logic             Done0;
    logic             Done1;

    typedef struct {
        logic [WIDTH-1:0] o0;
        logic [WIDTH-1:0] o1;
        logic             d0;
        logic             d1;
        int               step;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   step_no = 0;

    dual_down_counter #(.WIDTH(WIDTH)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .En      (En),
        .Slt     (Slt),
        .Load    (Load),
        .LoadVal (LoadVal),
        .Output0 (Output0),
        .Output1 (Output1),
        .Zero0   (Zero0),
        .Zero1   (Zero1),
        .Done0   (Done0),
        .Done1   (Done1)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int step, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, req);
        end
    endtask

    // Monitor: the DUT presents a fresh output after every rising edge.
    initial begin
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("Output0", e.step, Output0, e.o0);
                chk("Output1", e.step, Output1, e.o1);
                chk("Zero0",   e.step, WIDTH'(Zero0), WIDTH'(e.o0 == '0));
                chk("Zero1",   e.step, WIDTH'(Zero1), WIDTH'(e.o1 == '0));
                chk("Done0",   e.step, WIDTH'(Done0), WIDTH'(e.d0));
                chk("Done1",   e.step, WIDTH'(Done1), WIDTH'(e.d1));
            end
        end
    end

    // One clock of stimulus; expectation describes outputs after this edge.
    task automatic cyc(input logic rst_b, input logic load, input logic en, input logic slt,
                       input logic [WIDTH-1:0] lv, input logic [WIDTH-1:0] e0,
                       input logic [WIDTH-1:0] e1, input logic ed0, input logic ed1);
        exp_t e;
        Reset   = rst_b;
        Load    = load;
        En      = en;
        Slt     = slt;
        LoadVal = lv;
        step_no++;
        @(posedge Clk);
        e.o0 = e0; e.o1 = e1; e.d0 = ed0; e.d1 = ed1; e.step = step_no;
        exp_q.push_back(e);
        #1;
    endtask

    initial begin
        Reset = 1'b0; Load = 1'b0; En = 1'b0; Slt = 1'b0; LoadVal = '0;
        //  rst load en slt  LoadVal        Output0         Output1  D0 D1
        cyc(0, 0, 0, 0, 64'd0,           64'd0,          64'd0,  0, 0);
`ifdef AUTO_RELOAD_EN
        cyc(1, 1, 0, 0, 64'd2,           64'd2,          64'd0,  0, 0);
        cyc(1, 0, 1, 0, 64'd0,           64'd1,          64'd0,  0, 0);
        cyc(1, 0, 1, 0, 64'd0,           64'd2,          64'd0,  1, 0);
        cyc(1, 0, 1, 0, 64'd0,           64'd1,          64'd0,  0, 0);
        cyc(1, 0, 1, 0, 64'd0,           64'd2,          64'd0,  1, 0);
        cyc(1, 1, 0, 1, 64'd1,           64'd2,          64'd1,  0, 0);
        cyc(1, 0, 1, 1, 64'd0,           64'd2,          64'd1,  0, 1);
        cyc(1, 0, 1, 1, 64'd0,           64'd2,          64'd1,  0, 1);
        cyc(1, 0, 0, 1, 64'd0,           64'd2,          64'd1,  0, 0);
        cyc(1, 1, 1, 1, 64'd0,           64'd2,          64'd0,  0, 0);
        cyc(1, 0, 1, 1, 64'd0,           64'd2,          64'd0,  0, 0);
        cyc(1, 0, 1, 0, 64'd0,           64'd1,          64'd0,  0, 0);
        cyc(0, 1, 1, 0, 64'd9,           64'd0,          64'd0,  0, 0);
        cyc(1, 0, 1, 0, 64'd0,           64'd0,          64'd0,  0, 0);
`else
        cyc(1, 1, 0, 0, 64'd3,           64'd3,          64'd0,  0, 0);
        cyc(1, 0, 1, 0, 64'd0,           64'd2,          64'd0,  0, 0);
        cyc(1, 0, 1, 0, 64'd0,           64'd1,          64'd0,  0, 0);
        cyc(1, 0, 1, 0, 64'd0,           64'd0,          64'd0,  1, 0);
        cyc(1, 0, 1, 0, 64'd0,           64'd0,          64'd0,  0, 0);
        cyc(1, 0, 1, 0, 64'd0,           64'd0,          64'd0,  0, 0);
        cyc(1, 0, 1, 0, 64'd0,           64'd0,          64'd0,  0, 0);
        cyc(1, 1, 1, 1, 64'd5,           64'd0,          64'd5,  0, 0);
        cyc(1, 0, 1, 1, 64'd0,           64'd0,          64'd4,  0, 0);
        cyc(0, 0, 1, 1, 64'd0,           64'd0,          64'd0,  0, 0);
        cyc(1, 1, 0, 0, ALL1,            ALL1,           64'd0,  0, 0);
        cyc(1, 1, 0, 1, 64'd2,           ALL1,           64'd2,  0, 0);
        cyc(1, 0, 1, 1, 64'd0,           ALL1,           64'd1,  0, 0);
        cyc(1, 0, 1, 0, 64'd0,           ALL1 - 64'd1,   64'd1,  0, 0);
        cyc(1, 0, 1, 1, 64'd0,           ALL1 - 64'd1,   64'd0,  0, 1);
        cyc(1, 0, 0, 1, 64'd0,           ALL1 - 64'd1,   64'd0,  0, 0);
        cyc(1, 1, 0, 0, 64'd0,           64'd0,          64'd0,  0, 0);
        cyc(1, 0, 1, 0, 64'd0,           64'd0,          64'd0,  0, 0);
        cyc(1, 1, 0, 1, 64'd1,           64'd0,          64'd1,  0, 0);
        cyc(1, 0, 1, 1, 64'd0,           64'd0,          64'd0,  0, 1);
        cyc(1, 1, 0, 0, 64'd7,           64'd7,          64'd0,  0, 0);
        cyc(1, 0, 0, 0, 64'd0,           64'd7,          64'd0,  0, 0);
        cyc(1, 0, 1, 0, 64'd0,           64'd6,          64'd0,  0, 0);
        cyc(0, 1, 1, 0, 64'd9,           64'd0,          64'd0,  0, 0);
        cyc(1, 0, 1, 0, 64'd0,           64'd0,          64'd0,  0, 0);
`endif
        Reset = 1'b1; Load = 1'b0; En = 1'b0;
        repeat (3) @(negedge Clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
